code_lock_ctrl: RTL and testbench
=================================

# code_lock_ctrl

Sequencing controller for the serial pattern-lock datapath. It frames the serial input into N-bit attempts and compares each frame against a programmable code register. A match produces a Mealy-style unlock pulse; mismatches count failed attempts and, after MAX_TRIES consecutive failures, force a timed lockout. It sits between the user bit source and whatever consumes `unlock`.

## Interface
- N, default 3: code/frame length in bits, N >= 2.
- MAX_TRIES, default 3: consecutive failed frames allowed before lockout, >= 1.
- LOCK_CYCLES, default 16: lockout duration in clk cycles, >= 1.
- RESET_CODE, default 3'b001: code register value after reset, N bits wide.
- TW, derived: $clog2(MAX_TRIES+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- code_we  input  1  load code_in into the code register; honoured only in IDLE.
- code_in  input  N  new code, MSB = first bit of a frame.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial code bit.
- unlock  output  1  combinational pulse: the current bit completes a matching frame.
- fail  output  1  combinational pulse: the current bit completes a mismatching frame.
- locked_out  output  1  registered; high during lockout.
- tries_left  output  TW  registered; failed frames remaining before lockout.
- busy  output  1  registered; high while a frame is partially collected (COLLECT).

## Operation
- States: IDLE, COLLECT, LOCKOUT.
- Internal state: shift register sr[N-2:0], bit counter cnt (0..N-1), code register, tries counter, lockout timer.
- Bit order: first valid bit of a frame is the code MSB. Frame value = {sr, bit_in} on the N-th valid bit.
- IDLE:
  - code_we=1 loads code_in.
  - code_we has priority: a simultaneous bit_valid is dropped.
  - Otherwise bit_valid shifts bit_in into sr, sets cnt=1, and moves to COLLECT.
- COLLECT:
  - Each bit_valid shifts into sr and increments cnt.
  - Cycles without bit_valid hold all state; there is no timeout.
  - code_we is ignored.
- Frame completion: bit_valid=1 while cnt==N-1.
  - Match: unlock=1 in that cycle. tries reloads to MAX_TRIES. Go to IDLE, cnt=0.
  - Mismatch with tries>1: fail=1. tries decrements. Go to IDLE.
  - Mismatch with tries==1: fail=1. tries becomes 0. Timer loads LOCK_CYCLES-1. Go to LOCKOUT.
- LOCKOUT:
  - bit_valid and code_we are ignored.
  - The timer decrements each cycle.
  - In the cycle the timer is 0: transition to IDLE and reload tries to MAX_TRIES.
- Frames are non-overlapping: a match does not carry bits into the next frame.
- unlock and fail are never both 1. Both are 0 in LOCKOUT.
- Reset (asynchronous, any time, including mid-frame or mid-lockout):
  - state IDLE, cnt=0, sr=0, code=RESET_CODE, tries=MAX_TRIES, timer=0.
  - locked_out=0, busy=0. unlock and fail evaluate to 0.
- Unused encodings of state recover to IDLE.

## Timing
- unlock and fail are combinational from state, cnt, sr, code, bit_valid and bit_in. They are valid in the same cycle as the completing bit (0-cycle latency).
- tries_left, busy and locked_out update on the clock edge that ends the completing cycle.
- locked_out rises on the edge after the failing bit and stays high for exactly LOCK_CYCLES cycles.
- A bit presented in the first cycle after locked_out falls is accepted.
- A new frame may start in the cycle directly after a completing bit (back-to-back frames at one bit per cycle).
- code_we takes effect on the next edge. A frame started in the same or a later cycle compares against the new code.

## Test plan
- Reset, defaults, bits 0,0,1 on consecutive cycles: unlock=1 only in the third-bit cycle. tries_left stays 3. busy is 1 for two cycles.
- Bits 1,0,1 then 0,0,1: fail pulses at bit 3 with tries_left becoming 2. unlock at bit 6 with tries_left returning to 3.
- Three wrong frames (1,1,1 ×3):
  - fail on bits 3, 6 and 9; tries_left goes 2, 1, 0.
  - locked_out is high for exactly 16 cycles.
  - bits sent during lockout produce no unlock and no fail.
  - tries_left returns to 3 afterwards.
- In IDLE, code_we=1 with code_in=3'b110 and bit_valid=1 in the same cycle: the bit is dropped. Then 1,1,0 gives unlock and 0,0,1 gives fail.
- code_we asserted in COLLECT after bits 0,0: ignored. Completing bit 1 gives unlock.
- reset low after two bits of a frame, and again in lockout cycle 5: all outputs 0, tries_left=3, code restored to 001. Then 0,0,1 gives unlock.

Source files
------------

// File: rtl/code_lock_ctrl.sv
// Serial pattern lock: frames N serial bits and compares each frame against a programmable code.
// Latency: unlock/fail are combinational in the completing-bit cycle; tries_left/busy/locked_out update on the next edge.
// Backpressure: none; bits offered during lockout or alongside an IDLE code load are dropped, with no stall.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   code_we    load code_in into the code register (honoured only in IDLE)
//   code_in    new code, MSB is the first bit of a frame
//   bit_valid  bit_in carries a valid serial bit this cycle
//   bit_in     serial code bit
//   unlock     pulse: the current bit completes a frame equal to the code
//   fail       pulse: the current bit completes a frame that differs from the code
//   locked_out registered, high for LOCK_CYCLES cycles after the last permitted failure
//   tries_left registered, failed frames still allowed before lockout
//   busy       registered, high while a frame is partially collected
module code_lock_ctrl #(
    parameter int            N           = 3,
    parameter int            MAX_TRIES   = 3,
    parameter int            LOCK_CYCLES = 16,
    parameter logic [N-1:0]  RESET_CODE  = N'(1),
    localparam int           TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          code_we,
    input  logic [N-1:0]  code_in,
    input  logic          bit_valid,
    input  logic          bit_in,
    output logic          unlock,
    output logic          fail,
    output logic          locked_out,
    output logic [TW-1:0] tries_left,
    output logic          busy
);

    // Bit counter only needs to reach N-1; lockout timer only needs to hold LOCK_CYCLES-1.
    localparam int CW  = $clog2(N);
    localparam int LTW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CW-1:0]  CNT_LAST   = CW'(N - 1);
    localparam logic [TW-1:0]  TRIES_MAX  = TW'(MAX_TRIES);
    localparam logic [LTW-1:0] TIMER_LOAD = LTW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        LOCKOUT = 2'b10
    } state_t;

    state_t         state,  state_nxt;
    logic [CW-1:0]  cnt,    cnt_nxt;
    logic [N-2:0]   sr,     sr_nxt;
    logic [N-1:0]   code,   code_nxt;
    logic [TW-1:0]  tries,  tries_nxt;
    logic [LTW-1:0] timer,  timer_nxt;
    logic           locked_q;
    logic           busy_q;

    // Candidate frame: previously collected bits followed by the bit on the wire.
    // Its low N-1 bits are also the shifted-in value of sr, which keeps the
    // shift well-defined for N == 2 where sr is a single bit.
    logic [N-1:0]   frame;

    assign frame = {sr, bit_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            code     <= RESET_CODE;
            tries    <= TRIES_MAX;
            timer    <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sr       <= sr_nxt;
            code     <= code_nxt;
            tries    <= tries_nxt;
            timer    <= timer_nxt;
            locked_q <= (state_nxt == LOCKOUT);
            busy_q   <= (state_nxt == COLLECT);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        code_nxt  = code;
        tries_nxt = tries;
        timer_nxt = timer;
        unlock    = 1'b0;
        fail      = 1'b0;

        case (state)
            IDLE: begin
                // A code load wins over a bit offered in the same cycle.
                if (code_we) begin
                    code_nxt = code_in;
                end else if (bit_valid) begin
                    sr_nxt    = frame[N-2:0];
                    cnt_nxt   = CW'(1);
                    state_nxt = COLLECT;
                end
            end

            COLLECT: begin
                if (bit_valid) begin
                    if (cnt == CNT_LAST) begin
                        // Frame complete; nothing carries over into the next frame.
                        cnt_nxt   = '0;
                        sr_nxt    = '0;
                        state_nxt = IDLE;
                        if (frame == code) begin
                            unlock    = 1'b1;
                            tries_nxt = TRIES_MAX;
                        end else begin
                            fail = 1'b1;
                            // <= 1 rather than == 1 so a corrupted zero count
                            // still lands in lockout instead of wrapping.
                            if (tries <= TW'(1)) begin
                                tries_nxt = '0;
                                timer_nxt = TIMER_LOAD;
                                state_nxt = LOCKOUT;
                            end else begin
                                tries_nxt = tries - TW'(1);
                            end
                        end
                    end else begin
                        sr_nxt  = frame[N-2:0];
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            LOCKOUT: begin
                // Timer runs LOCK_CYCLES-1 down to 0, giving LOCK_CYCLES cycles here.
                if (timer == '0) begin
                    state_nxt = IDLE;
                    tries_nxt = TRIES_MAX;
                end else begin
                    timer_nxt = timer - LTW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                sr_nxt    = '0;
            end
        endcase
    end

    assign locked_out = locked_q;
    assign busy       = busy_q;
    assign tries_left = tries;

endmodule

// File: tb/tb_code_lock_ctrl.sv
module tb_code_lock_ctrl;

    localparam int N  = 3;
    localparam int MT = 3;
    localparam int LC = 16;
    localparam int TW = $clog2(MT + 1);

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          code_we   = 1'b0;
    logic [N-1:0]  code_in   = '0;
    logic          bit_valid = 1'b0;
    logic          bit_in    = 1'b0;
    logic          unlock;
    logic          fail;
    logic          locked_out;
    logic [TW-1:0] tries_left;
    logic          busy;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .N(N), .MAX_TRIES(MT), .LOCK_CYCLES(LC), .RESET_CODE(3'b001)
    ) dut (
        .clk(clk), .reset(reset), .code_we(code_we), .code_in(code_in),
        .bit_valid(bit_valid), .bit_in(bit_in), .unlock(unlock), .fail(fail),
        .locked_out(locked_out), .tries_left(tries_left), .busy(busy)
    );

    typedef struct {
        logic          unlock;
        logic          fail;
        logic          locked_out;
        logic [TW-1:0] tries;
        logic          busy;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: a list of bits received so far in the frame, a plain
    // try count, and a count of lockout cycles still to serve.
    int m_bits[$];
    int m_tries;
    int m_lock;
    int m_code;

    task automatic m_reset();
        m_bits.delete();
        m_tries = MT;
        m_lock  = 0;
        m_code  = 1;
    endtask

    task automatic model(input bit we, input int cin, input bit bv, input bit b, output exp_t e);
        int val;
        e.locked_out = (m_lock > 0);
        e.tries      = TW'(m_tries);
        e.busy       = (m_bits.size() > 0);
        e.unlock     = 1'b0;
        e.fail       = 1'b0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_tries = MT;
        end else if (m_bits.size() == 0 && we) begin
            m_code = cin;
        end else if (bv) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == N) begin
                val = 0;
                foreach (m_bits[i]) val = val * 2 + m_bits[i];
                m_bits.delete();
                if (val == m_code) begin
                    e.unlock = 1'b1;
                    m_tries  = MT;
                end else begin
                    e.fail = 1'b1;
                    m_tries--;
                    if (m_tries == 0) m_lock = LC;
                end
            end
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; the expected
    // response for this cycle is queued for the monitor.
    task automatic step(input bit we, input int cin, input bit bv, input bit b);
        exp_t e;
        reset     = 1'b1;
        code_we   = we;
        code_in   = N'(cin);
        bit_valid = bv;
        bit_in    = b;
        model(we, cin, bv, b, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step();
        exp_t e;
        reset     = 1'b0;
        code_we   = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        m_reset();
        e.unlock     = 1'b0;
        e.fail       = 1'b0;
        e.locked_out = 1'b0;
        e.tries      = TW'(MT);
        e.busy       = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int v);
        for (int i = N - 1; i >= 0; i--) step(1'b0, 0, 1'b1, bit'((v >> i) & 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("unlock",     32'(unlock),     32'(e.unlock));
                chk("fail",       32'(fail),       32'(e.fail));
                chk("locked_out", 32'(locked_out), 32'(e.locked_out));
                chk("tries_left", 32'(tries_left), 32'(e.tries));
                chk("busy",       32'(busy),       32'(e.busy));
            end
        end
    end

    initial begin
        int r;
        m_reset();
        @(posedge clk);
        #1;
        rst_step();
        rst_step();

        // Default code accepted, then a miss followed by a hit.
        send_frame(3'b001);
        send_frame(3'b101);
        send_frame(3'b001);

        // Three misses into lockout; bits offered during lockout are ignored.
        send_frame(3'b111);
        send_frame(3'b111);
        send_frame(3'b111);
        for (int i = 0; i < LC; i++) step(1'b0, 0, 1'b1, bit'($urandom_range(0, 1)));
        idle(2);

        // Code load drops the simultaneous bit; new code then governs.
        step(1'b1, 3'b110, 1'b1, 1'b1);
        send_frame(3'b110);
        send_frame(3'b001);

        // Back to 001, then code_we during COLLECT is ignored.
        step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 3'b110, 1'b0, 1'b0);
        step(1'b1, 3'b110, 1'b1, 1'b1);

        // Reset mid-frame restores the default code.
        step(1'b1, 3'b110, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        rst_step();
        send_frame(3'b001);

        // Reset in the fifth lockout cycle.
        send_frame(3'b111);
        send_frame(3'b111);
        send_frame(3'b111);
        idle(4);
        rst_step();
        send_frame(3'b001);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) rst_step();
            else step(r < 8, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                      bit'($urandom_range(0, 1)));
        end
        idle(2);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
